dmem_responder: RTL and testbench

- Data-memory responder for the MEM stage. It consumes the MemRead/MemWrite, address (ALU result) and store data (RS2) that the EX/MEM pipeline register presents.
- Models a word-addressed data RAM with a fixed multi-cycle access latency.
- Holds the pipeline with Stall_o until the access finishes.
- Returns load data to the MEM/WB path with a one-cycle valid strobe.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the EX/MEM register and the data-memory responder.
// The master drives requests; the slave (responder) returns data, valid, stall and error.
interface dmem_responder_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] ADDR_i;
  logic [31:0] WRdata_i;
  logic [31:0] RDdata_o;
  logic        RDvalid_o;
  logic        Stall_o;
  logic        Err_o;

  modport master (
    output MemRead_i, MemWrite_i, ADDR_i, WRdata_i,
    input  RDdata_o, RDvalid_o, Stall_o, Err_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, ADDR_i, WRdata_i,
    output RDdata_o, RDvalid_o, Stall_o, Err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// MEM-stage data RAM with fixed multi-cycle latency; stalls the pipeline until the access commits.
// Optional macro DMEM_MISALIGN_CHECK_EN rejects accesses whose byte offset is non-zero.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  dmem_responder_if.slave bus
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              mem_we;
  logic              stall;
  logic              req;
  logic [31:0]       mem_q [DEPTH];

`ifdef DMEM_MISALIGN_CHECK_EN
  logic [1:0]        off_q, off_d;
  logic              err_q, err_d;
  logic              unused_addr;
  assign unused_addr = ^bus.ADDR_i[31:AW+2];
`else
  logic              unused_addr;
  assign unused_addr = ^{bus.ADDR_i[31:AW+2], bus.ADDR_i[1:0]};
`endif

  assign req = bus.MemRead_i | bus.MemWrite_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    mem_we     = 1'b0;
    stall      = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    off_d      = off_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        stall = req;
        if (req) begin
          // Both strobes high is treated as a store.
          is_store_d = bus.MemWrite_i;
          idx_d      = bus.ADDR_i[AW+1:2];
          wdata_d    = bus.WRdata_i;
          cnt_d      = CntW'(LATENCY - 1);
`ifdef DMEM_MISALIGN_CHECK_EN
          off_d      = bus.ADDR_i[1:0];
`endif
          state_d    = StBusy;
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StDone;
`ifdef DMEM_MISALIGN_CHECK_EN
          if (off_q != 2'b00) err_d = 1'b1;
          else
`endif
          if (is_store_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d  = mem_q[idx_q];
            rvalid_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      off_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
`ifdef DMEM_MISALIGN_CHECK_EN
      off_q      <= off_d;
      err_q      <= err_d;
`endif
    end
  end

  // RAM array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Stall is masked while reset is asserted so the pipeline is never held in reset.
  assign bus.Stall_o   = stall & rst_n_i;
  assign bus.RDdata_o  = rdata_q;
  assign bus.RDvalid_o = rvalid_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bus.Err_o     = err_q;
`else
  assign bus.Err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against an array-based memory model.
// Honours DMEM_MISALIGN_CHECK_EN when the same define is given to the build.
module tb_dmem_responder;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned AW      = 8;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MisalignEn = 1'b1;
`else
  localparam bit MisalignEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if dif ();

  dmem_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY),
    .AW     (AW)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (dif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
  endtask

  task automatic idle(input int n);
    dif.MemRead_i  = 1'b0;
    dif.MemWrite_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one request and holds it until the DONE cycle, then checks against the model.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int valid_cyc);
    int  stall_n = 0;
    bit  noisy   = 1'b0;
    int  idx;
    bit  bad;
    bit  exp_valid;
    dif.MemRead_i  = rd;
    dif.MemWrite_i = wr;
    dif.ADDR_i     = addr;
    dif.WRdata_i   = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dif.Stall_o) begin
        stall_n++;
        if (dif.RDvalid_o || dif.Err_o) noisy = 1'b1;
      end else begin
        break;
      end
    end
    check("stall_len", stall_n, LATENCY + 1);
    check("busy_quiet", {31'b0, noisy}, 32'd0);
    idx       = int'((addr / 4) % DEPTH);
    bad       = MisalignEn && (addr % 4 != 0);
    exp_valid = rd && !wr && !bad;
    if (!bad) begin
      if (wr) ref_mem[idx] = wd;
      else if (rd) ref_rdata = ref_mem[idx];
    end
    check("rdvalid", {31'b0, dif.RDvalid_o}, {31'b0, exp_valid});
    check("rddata", dif.RDdata_o, ref_rdata);
    check("err", {31'b0, dif.Err_o}, {31'b0, bad});
    valid_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v1;
    int v2;
    dif.MemRead_i  = 1'b0;
    dif.MemWrite_i = 1'b0;
    dif.ADDR_i     = '0;
    dif.WRdata_i   = '0;
    ref_rdata      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'b0, dif.Stall_o}, 32'd0);
    check("rst_rdata", dif.RDdata_o, 32'd0);
    check("rst_rdvalid", {31'b0, dif.RDvalid_o}, 32'd0);
    check("rst_err", {31'b0, dif.Err_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("idle_stall", {31'b0, dif.Stall_o}, 32'd0);

    // Preload every word so later loads have a defined model value.
    for (int i = 0; i < int'(DEPTH); i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, v1);

    // Store then load.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, v1);
    idle(1);
    access(1'b1, 1'b0, 32'h10, 32'h0, v1);
    check("t1_load", dif.RDdata_o, 32'hDEADBEEF);

    // Index wraps modulo DEPTH.
    access(1'b0, 1'b1, 32'h400, 32'h12345678, v1);
    access(1'b1, 1'b0, 32'h0, 32'h0, v1);
    check("t2_wrap", dif.RDdata_o, 32'h12345678);

    // Both strobes high behaves as a store.
    access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, v1);
    access(1'b1, 1'b0, 32'h20, 32'h0, v1);
    check("t3_both", dif.RDdata_o, 32'hA5A5A5A5);

    // Reset during BUSY abandons the store.
    access(1'b0, 1'b1, 32'h30, 32'h0, v1);
    idle(1);
    dif.MemWrite_i = 1'b1;
    dif.ADDR_i     = 32'h30;
    dif.WRdata_i   = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("t4_busy_stall", {31'b0, dif.Stall_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_stall", {31'b0, dif.Stall_o}, 32'd0);
    check("t4_rst_valid", {31'b0, dif.RDvalid_o}, 32'd0);
    @(posedge clk);
    #1;
    dif.MemWrite_i = 1'b0;
    ref_rdata = '0;
    rst_n = 1'b1;
    idle(1);
    access(1'b1, 1'b0, 32'h30, 32'h0, v1);
    check("t4_abandoned", dif.RDdata_o, 32'h0);

    // Back-to-back loads.
    access(1'b0, 1'b1, 32'h0, 32'd1, v1);
    access(1'b0, 1'b1, 32'h4, 32'd2, v1);
    idle(1);
    access(1'b1, 1'b0, 32'h0, 32'h0, v1);
    check("t5_first", dif.RDdata_o, 32'd1);
    access(1'b1, 1'b0, 32'h4, 32'h0, v2);
    check("t5_second", dif.RDdata_o, 32'd2);
    check("t5_spacing", 32'(v2 - v1), LATENCY + 2);
    idle(1);
    check("t5_no_dup", {31'b0, dif.RDvalid_o}, 32'd0);

    // Misaligned access: rejected with the check enabled, otherwise maps to word 8.
    access(1'b0, 1'b1, 32'h20, 32'h11112222, v1);
    access(1'b1, 1'b0, 32'h22, 32'h0, v1);
    access(1'b0, 1'b1, 32'h22, 32'h33334444, v1);
    access(1'b1, 1'b0, 32'h20, 32'h0, v1);
    check("t6_word8", dif.RDdata_o, MisalignEn ? 32'h11112222 : 32'h33334444);

    // Random mix of loads, stores and gaps.
    for (int i = 0; i < 80; i++) begin
      bit rd;
      bit wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) idle($urandom_range(1, 2));
      else access(rd, wr, $urandom, $urandom, v1);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
